sign_extender_left_shifter: RTL and testbench
=============================================

# sign_extender_left_shifter

Immediate-conditioning datapath block for the 32-bit core. It provides a combinational 16→32 sign extension and a combinational 32-bit logical left shift by two. It also provides a registered branch/jump byte offset equal to sign_extend(imm) << 2. It sits between instruction decode and the branch-target adder / ALU operand mux.

## Interface
Parameters:
- IMM_WIDTH, 16, width of the unextended immediate
- DATA_WIDTH, 32, width of extended/shifted words
- SHIFT_AMT, 2, fixed left-shift distance in bits

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- unextended  input  IMM_WIDTH  raw immediate field
- unshifted  input  DATA_WIDTH  word to be shifted
- in_valid  input  1  qualifies unextended for the registered offset path
- extended  output  DATA_WIDTH  combinational sign extension of unextended
- shifted  output  DATA_WIDTH  combinational unshifted << SHIFT_AMT
- offset_q  output  DATA_WIDTH  registered sign_extend(unextended) << SHIFT_AMT
- offset_valid_q  output  1  registered copy of in_valid

## Operation
Sign extension:
- extended[IMM_WIDTH-1:0] = unextended.
- extended[DATA_WIDTH-1:IMM_WIDTH] = replicated unextended[IMM_WIDTH-1].
- Examples: 16'hf00f → 32'hfffff00f; 16'h0007 → 32'h00000007.

Left shift:
- shifted = {unshifted[DATA_WIDTH-1-SHIFT_AMT:0], SHIFT_AMT'b0}. This is a logical shift.
- The top SHIFT_AMT bits are discarded. No overflow flag is produced.
- Example: 32'hffffffff → 32'hfffffffc.

Offset path:
- On each clk rising edge where in_valid=1, offset_q ← sign_extend(unextended) << SHIFT_AMT.
- On each clk rising edge, offset_valid_q ← in_valid.
- When in_valid=0, offset_q holds its previous value.

Widths and legality:
- Constraints: IMM_WIDTH < DATA_WIDTH and 0 ≤ SHIFT_AMT < DATA_WIDTH. Elaboration must fail otherwise.
- SHIFT_AMT=0 makes shifted equal to unshifted.

No internal state exists besides offset_q and offset_valid_q.

## Timing
- extended and shifted are purely combinational, with zero cycles of latency.
  - They do not depend on clk or rst_n.
  - They are valid after input settling and remain valid while rst_n=0.
- offset_q and offset_valid_q have 1-cycle latency from the sampling edge.
- Reset values: offset_q = 0 and offset_valid_q = 0.
  - Both take these values immediately on rst_n falling, independent of clk.
- Reset release is synchronous-safe: the first capture occurs on the first rising edge after rst_n goes high.
- Reset asserted mid-stream clears both registers at once. A pending in_valid is lost.
- Back-to-back in_valid pulses are accepted every cycle. There is no backpressure.

## Structure
- Shared package core_pkg holds:
  - DATA_WIDTH = 32
  - IMM_WIDTH = 16
  - typedef word_t (logic [31:0])
  - typedef imm_t (logic [15:0])
- Two combinational leaf sub-modules are instantiated:
  - sign_extender (unextended → extended)
  - left_shifter (unshifted → shifted)
- A second sign_extender/left_shifter pair feeds the offset register. This keeps each leaf reusable elsewhere in the core.
- The top level contains only the two instance pairs and one always_ff block for offset_q and offset_valid_q.

## Test plan
- Negative immediate: unextended=16'hf00f → extended=32'hfffff00f within the same delta/settle window (check after 30 time units).
- Positive immediate: unextended=16'h0007 → extended=32'h00000007. Also check the boundaries 16'h7fff → 32'h00007fff and 16'h8000 → 32'hffff8000.
- Shift with bit loss: unshifted=32'hffffffff → shifted=32'hfffffffc. Also check 32'h40000001 → 32'h00000004 and 32'h00000000 → 32'h00000000.
- Offset register: hold rst_n=0 and verify offset_q=0 and offset_valid_q=0. Release reset, then drive unextended=16'hfffe with in_valid=1 for one cycle.
  - Next edge: offset_q=32'hfffffff8 and offset_valid_q=1.
  - Following edge, with in_valid=0: offset_q holds and offset_valid_q=0.
- Asynchronous reset mid-operation: with offset_q=32'h0000001c, pulse rst_n low between clock edges. Both registered outputs go to 0 without a clock edge. The combinational outputs keep tracking their inputs throughout.
- Random sweep: 1000 random unextended/unshifted values compared against the reference expressions {{16{imm[15]}}, imm} and {x[29:0], 2'b00} every cycle.

Source files
------------

// File: rtl/sign_extender_left_shifter_pkg.sv
//------------------------------------------------------------------------------
// Module   : core_pkg
// Purpose  : Shared widths and word types for the 32-bit core datapath.
// Contents : DATA_WIDTH, IMM_WIDTH, SHIFT_AMT, word_t, imm_t
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package core_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int IMM_WIDTH  = 16;
   localparam int SHIFT_AMT  = 2;

   typedef logic [31:0] word_t;
   typedef logic [15:0] imm_t;
endpackage

`default_nettype wire

// File: rtl/sign_extender_left_shifter_if.sv
//------------------------------------------------------------------------------
// Module   : sign_extender_left_shifter_if
// Purpose  : Bundles the immediate-conditioning datapath signals.
// Ports    : unextended, unshifted, in_valid      (master -> slave)
//            extended, shifted, offset_q,
//            offset_valid_q                        (slave -> master)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sign_extender_left_shifter_if
   import core_pkg::*;
#(
   parameter int IMM_WIDTH  = core_pkg::IMM_WIDTH,
   parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
);
   logic [IMM_WIDTH-1:0]  unextended;
   logic [DATA_WIDTH-1:0] unshifted;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] extended;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] offset_q;
   logic                  offset_valid_q;

   // Decode side drives the raw fields.
   modport master (
      output unextended, unshifted, in_valid,
      input  extended, shifted, offset_q, offset_valid_q
   );

   // Conditioning block consumes the raw fields.
   modport slave (
      input  unextended, unshifted, in_valid,
      output extended, shifted, offset_q, offset_valid_q
   );
endinterface

`default_nettype wire

// File: rtl/left_shifter.sv
//------------------------------------------------------------------------------
// Module   : left_shifter
// Purpose  : Combinational fixed-distance logical left shift; bits shifted
//            out of the top are dropped.
// Ports    : unshifted [DATA_WIDTH] -> shifted [DATA_WIDTH]
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module left_shifter
   import core_pkg::*;
#(
   parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
   parameter int SHIFT_AMT  = core_pkg::SHIFT_AMT
) (
   input  wire logic [DATA_WIDTH-1:0] unshifted,
   output      logic [DATA_WIDTH-1:0] shifted
);
   generate
      if (SHIFT_AMT < 0 || SHIFT_AMT >= DATA_WIDTH) begin : g_bad_shift
         $error("left_shifter: SHIFT_AMT must be in [0, DATA_WIDTH)");
      end
      // A zero-width zero-fill concatenation is illegal, so SHIFT_AMT=0 is a
      // straight pass-through.
      if (SHIFT_AMT == 0) begin : g_pass
         assign shifted = unshifted;
      end else begin : g_shift
         assign shifted = {unshifted[DATA_WIDTH-1-SHIFT_AMT:0], {SHIFT_AMT{1'b0}}};
      end
   endgenerate
endmodule

`default_nettype wire

// File: rtl/sign_extender.sv
//------------------------------------------------------------------------------
// Module   : sign_extender
// Purpose  : Combinational sign extension of an immediate field.
// Ports    : unextended [IMM_WIDTH]  -> extended [DATA_WIDTH]
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sign_extender
   import core_pkg::*;
#(
   parameter int IMM_WIDTH  = core_pkg::IMM_WIDTH,
   parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
   input  wire logic [IMM_WIDTH-1:0]  unextended,
   output      logic [DATA_WIDTH-1:0] extended
);
   generate
      if (IMM_WIDTH >= DATA_WIDTH) begin : g_bad_width
         $error("sign_extender: IMM_WIDTH must be smaller than DATA_WIDTH");
      end
   endgenerate

   assign extended = {{(DATA_WIDTH-IMM_WIDTH){unextended[IMM_WIDTH-1]}}, unextended};
endmodule

`default_nettype wire

// File: rtl/sign_extender_left_shifter.sv
//------------------------------------------------------------------------------
// Module   : sign_extender_left_shifter
// Purpose  : Immediate conditioning between decode and the branch-target
//            adder / ALU operand mux. Combinational sign-extend and shift,
//            plus a registered byte offset sign_extend(imm) << SHIFT_AMT.
// Ports    : clk, rst_n (async, active-low)
//            bus.slave : unextended, unshifted, in_valid ->
//                        extended, shifted, offset_q, offset_valid_q
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sign_extender_left_shifter
   import core_pkg::*;
#(
   parameter int IMM_WIDTH  = core_pkg::IMM_WIDTH,
   parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
   parameter int SHIFT_AMT  = core_pkg::SHIFT_AMT
) (
   input wire logic               clk,
   input wire logic               rst_n,
   sign_extender_left_shifter_if.slave bus
);
   logic [DATA_WIDTH-1:0] w_offset_ext;
   logic [DATA_WIDTH-1:0] w_offset_next;
   logic [DATA_WIDTH-1:0] r_offset_q;
   logic                  r_offset_valid_q;

   // Pair driving the combinational outputs.
   sign_extender #(.IMM_WIDTH(IMM_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ext (
      .unextended (bus.unextended),
      .extended   (bus.extended)
   );

   left_shifter #(.DATA_WIDTH(DATA_WIDTH), .SHIFT_AMT(SHIFT_AMT)) u_shl (
      .unshifted (bus.unshifted),
      .shifted   (bus.shifted)
   );

   // Dedicated pair for the offset path so the shift input stays independent
   // of the unshifted operand.
   sign_extender #(.IMM_WIDTH(IMM_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_off_ext (
      .unextended (bus.unextended),
      .extended   (w_offset_ext)
   );

   left_shifter #(.DATA_WIDTH(DATA_WIDTH), .SHIFT_AMT(SHIFT_AMT)) u_off_shl (
      .unshifted (w_offset_ext),
      .shifted   (w_offset_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_offset_q       <= '0;
         r_offset_valid_q <= 1'b0;
      end else begin
         r_offset_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            r_offset_q <= w_offset_next;
         end
      end
   end

   assign bus.offset_q       = r_offset_q;
   assign bus.offset_valid_q = r_offset_valid_q;
endmodule

`default_nettype wire

// File: tb/tb_sign_extender_left_shifter.sv
//------------------------------------------------------------------------------
// Module   : tb_sign_extender_left_shifter
// Purpose  : Self-checking bench for sign_extender_left_shifter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sign_extender_left_shifter;
   import core_pkg::*;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   sign_extender_left_shifter_if bus ();

   sign_extender_left_shifter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: arithmetic meaning rather than bit slicing.
   function automatic word_t ref_ext(input imm_t imm);
      int v;
      v = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
      return word_t'(v);
   endfunction

   function automatic word_t ref_shl(input word_t x);
      longint unsigned p;
      p = (longint'(x) * 4) % 64'h1_0000_0000;
      return word_t'(p);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bus.unextended = 16'h1234;
      bus.unshifted  = 32'h0;
      bus.in_valid   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.offset_q !== 32'h0) begin
         fails++;
         $display("FAIL reset_offset_q got %h expected %h", bus.offset_q, 32'h0);
      end
      tests++;
      if (bus.offset_valid_q !== 1'b0) begin
         fails++;
         $display("FAIL reset_offset_valid got %b expected 0", bus.offset_valid_q);
      end
      tests++;
      if (bus.extended !== 32'h00001234) begin
         fails++;
         $display("FAIL ext_during_reset got %h expected %h", bus.extended, 32'h00001234);
      end
   endtask

   task automatic test_sign_extend();
      imm_t  imms [4] = '{16'hf00f, 16'h0007, 16'h7fff, 16'h8000};
      word_t exps [4] = '{32'hfffff00f, 32'h00000007, 32'h00007fff, 32'hffff8000};
      for (int i = 0; i < 4; i++) begin
         bus.unextended = imms[i];
         #30;
         tests++;
         if (bus.extended !== exps[i]) begin
            fails++;
            $display("FAIL sign_extend[%0d] got %h expected %h", i, bus.extended, exps[i]);
         end
      end
   endtask

   task automatic test_shift();
      word_t ins  [3] = '{32'hffffffff, 32'h40000001, 32'h00000000};
      word_t exps [3] = '{32'hfffffffc, 32'h00000004, 32'h00000000};
      for (int i = 0; i < 3; i++) begin
         bus.unshifted = ins[i];
         #30;
         tests++;
         if (bus.shifted !== exps[i]) begin
            fails++;
            $display("FAIL shift[%0d] got %h expected %h", i, bus.shifted, exps[i]);
         end
      end
   endtask

   task automatic test_offset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      tests++;
      if (bus.offset_q !== 32'h0 || bus.offset_valid_q !== 1'b0) begin
         fails++;
         $display("FAIL offset_held_reset got %h/%b expected 0/0", bus.offset_q, bus.offset_valid_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.unextended = 16'hfffe;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (bus.offset_q !== 32'hfffffff8 || bus.offset_valid_q !== 1'b1) begin
         fails++;
         $display("FAIL offset_capture got %h/%b expected fffffff8/1", bus.offset_q, bus.offset_valid_q);
      end
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.unextended = 16'h0123;
      @(posedge clk);
      #1;
      tests++;
      if (bus.offset_q !== 32'hfffffff8 || bus.offset_valid_q !== 1'b0) begin
         fails++;
         $display("FAIL offset_hold got %h/%b expected fffffff8/0", bus.offset_q, bus.offset_valid_q);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.unextended = 16'h0007;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (bus.offset_q !== 32'h0000001c) begin
         fails++;
         $display("FAIL async_setup got %h expected 0000001c", bus.offset_q);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      bus.unextended = 16'h8001;
      bus.unshifted  = 32'h80000003;
      #1;
      tests++;
      if (bus.offset_q !== 32'h0 || bus.offset_valid_q !== 1'b0) begin
         fails++;
         $display("FAIL async_clear got %h/%b expected 0/0", bus.offset_q, bus.offset_valid_q);
      end
      tests++;
      if (bus.extended !== 32'hffff8001 || bus.shifted !== 32'h0000000c) begin
         fails++;
         $display("FAIL comb_in_reset got %h/%h expected ffff8001/0000000c", bus.extended, bus.shifted);
      end
      // Pending in_valid must be lost across the edge while reset is held.
      @(posedge clk);
      #1;
      tests++;
      if (bus.offset_q !== 32'h0 || bus.offset_valid_q !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold_edge got %h/%b expected 0/0", bus.offset_q, bus.offset_valid_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_random();
      word_t exp_off;
      logic  exp_v;
      imm_t  imm;
      word_t x;
      logic  v;
      int    bad;
      exp_off = bus.offset_q;
      exp_v   = bus.offset_valid_q;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         imm = imm_t'($urandom);
         x   = $urandom;
         v   = 1'($urandom_range(0, 1));
         bus.unextended = imm;
         bus.unshifted  = x;
         bus.in_valid   = v;
         #1;
         tests++;
         if (bus.extended !== ref_ext(imm) || bus.shifted !== ref_shl(x)) begin
            fails++;
            bad++;
            if (bad < 10)
               $display("FAIL random_comb[%0d] got %h/%h expected %h/%h",
                        i, bus.extended, bus.shifted, ref_ext(imm), ref_shl(x));
         end
         if (v) exp_off = ref_shl(ref_ext(imm));
         exp_v = v;
         @(posedge clk);
         #1;
         tests++;
         if (bus.offset_q !== exp_off || bus.offset_valid_q !== exp_v) begin
            fails++;
            bad++;
            if (bad < 10)
               $display("FAIL random_offset[%0d] got %h/%b expected %h/%b",
                        i, bus.offset_q, bus.offset_valid_q, exp_off, exp_v);
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_sign_extend();
      test_shift();
      test_offset();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
